// File: rtl/sequence_checker.sv
// sequence_checker: receiving-end checker for an arithmetic-sequence stream.
// It verifies the first value, every step, the termination point and done
// signalling, then holds a pass/fail verdict with an error code and the index
// of the first offending sample.
// Optional feature macro: SEQ_CHECKER_CONTINUE_EN. When it is defined, value
// mismatches are counted on err_count and do not end the check. The verdict is
// then given at termination.
module sequence_checker #(
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] start_value,
  input  logic signed [DATA_W-1:0] step,
  input  logic signed [DATA_W-1:0] range_min,
  input  logic signed [DATA_W-1:0] range_max,
  input  logic                     seq_valid,
  input  logic signed [DATA_W-1:0] seq_value,
  input  logic                     seq_done,
  output logic                     busy,
  output logic                     pass,
  output logic                     fail,
  output logic [2:0]               err_code,
  output logic [CNT_W-1:0]         err_index,
  output logic [CNT_W-1:0]         sample_count,
  output logic signed [DATA_W-1:0] expected
`ifdef SEQ_CHECKER_CONTINUE_EN
  ,
  output logic [CNT_W-1:0]         err_count
`endif
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  localparam logic [2:0] ERR_NONE       = 3'd0;
  localparam logic [2:0] ERR_CFG        = 3'd1;
  localparam logic [2:0] ERR_VALUE      = 3'd2;
  localparam logic [2:0] ERR_EARLY_DONE = 3'd3;
  localparam logic [2:0] ERR_OVERRUN    = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT    = 3'd5;
  localparam logic [2:0] ERR_ABORT      = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_TRACK  = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  state_t                     state_q;
  logic                       busy_q;
  logic                       pass_q;
  logic                       fail_q;
  logic [2:0]                 err_code_q;
  logic [CNT_W-1:0]           err_index_q;
  logic [CNT_W-1:0]           count_q;
  logic signed [DATA_W-1:0]   expected_q;
  logic                       last_q;
  logic [TMO_W-1:0]           tmo_q;
`ifdef SEQ_CHECKER_CONTINUE_EN
  logic [CNT_W-1:0]           err_count_q;
  logic                       val_err;
`endif

  // Configuration latched at arm time so the source may change its inputs later.
  logic signed [DATA_W-1:0]   step_q;
  logic signed [DATA_W-1:0]   min_q;
  logic signed [DATA_W-1:0]   max_q;

  // Next-state helpers for the tracking states.
  logic signed [DATA_W:0]     next_sum;
  logic                       last_d;
  logic                       last_after;
  logic                       mism;
  logic                       acc;
  logic                       term;
  logic [2:0]                 term_code;
  logic [CNT_W-1:0]           term_idx;
  logic [CNT_W-1:0]           count_d;
  logic [TMO_W-1:0]           tmo_d;
  logic                       cfg_bad;

  // Saturating increment for the counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Set when the value after the current one lies outside the range. The value
  // is taken as a widened sum so that it cannot wrap.
  function automatic logic last_of(input logic signed [DATA_W:0]   nxt,
                                   input logic signed [DATA_W-1:0] stp,
                                   input logic signed [DATA_W-1:0] mn,
                                   input logic signed [DATA_W-1:0] mx);
    logic signed [DATA_W:0] mn_x;
    logic signed [DATA_W:0] mx_x;
    logic                   up;
    logic                   down;
    mn_x = {mn[DATA_W-1], mn};
    mx_x = {mx[DATA_W-1], mx};
    up   = !stp[DATA_W-1] && (stp != '0);
    down = stp[DATA_W-1];
    return (up && (nxt > mx_x)) || (down && (nxt < mn_x));
  endfunction

  // Decide the sample, done, timeout and abort events for this cycle. The
  // priority is abort, then sample check, then done, then timeout.
  always_comb begin
    next_sum   = {expected_q[DATA_W-1], expected_q} + {step_q[DATA_W-1], step_q};
    last_d     = last_of(next_sum, step_q, min_q, max_q);
    mism       = (seq_value != expected_q);
    cfg_bad    = (step == '0) || (start_value < range_min) || (start_value > range_max);
    tmo_d      = seq_valid ? '0 : tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
    acc        = 1'b0;
    term       = 1'b0;
    term_code  = ERR_NONE;
    term_idx   = count_q;
    last_after = last_q;
    count_d    = count_q;
    if (!enable) begin
      term      = 1'b1;
      term_code = ERR_ABORT;
    end else if (seq_valid && last_q) begin
      term      = 1'b1;
      term_code = ERR_OVERRUN;
`ifndef SEQ_CHECKER_CONTINUE_EN
    end else if (seq_valid && mism) begin
      term      = 1'b1;
      term_code = ERR_VALUE;
`endif
    end else begin
      if (seq_valid) begin
        acc        = 1'b1;
        last_after = last_d;
        count_d    = sat_inc(count_q);
      end
      // Done is judged after any sample of the same cycle has been taken in.
      if (seq_done && ((state_q == S_TRACK) || seq_valid)) begin
        term      = 1'b1;
        term_idx  = count_d;
        term_code = last_after ? ERR_NONE : ERR_EARLY_DONE;
      end else if (!seq_valid && (tmo_q == TMO_LAST)) begin
        term      = 1'b1;
        term_code = ERR_TIMEOUT;
      end
    end
`ifdef SEQ_CHECKER_CONTINUE_EN
    val_err = acc && mism;
`endif
  end

  // Latch the configuration when the checker is armed from IDLE.
  always_ff @(posedge clk) begin
    if ((state_q == S_IDLE) && enable) begin
      step_q <= step;
      min_q  <= range_min;
      max_q  <= range_max;
    end
  end

  // Checker FSM with registered verdict, error capture and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_index_q <= '0;
      count_q     <= '0;
      expected_q  <= '0;
      last_q      <= 1'b0;
      tmo_q       <= '0;
`ifdef SEQ_CHECKER_CONTINUE_EN
      err_count_q <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable) begin
            pass_q      <= 1'b0;
            err_index_q <= '0;
            count_q     <= '0;
            expected_q  <= start_value;
            last_q      <= 1'b0;
            tmo_q       <= '0;
`ifdef SEQ_CHECKER_CONTINUE_EN
            err_count_q <= '0;
`endif
            if (cfg_bad) begin
              state_q    <= S_REPORT;
              busy_q     <= 1'b0;
              fail_q     <= 1'b1;
              err_code_q <= ERR_CFG;
            end else begin
              state_q    <= S_ARMED;
              busy_q     <= 1'b1;
              fail_q     <= 1'b0;
              err_code_q <= ERR_NONE;
            end
          end
        end

        S_ARMED, S_TRACK: begin
          tmo_q <= tmo_d;
          // Expected advances from the expected value, not from the observed one.
          if (acc) begin
            count_q    <= count_d;
            expected_q <= $signed(next_sum[DATA_W-1:0]);
            last_q     <= last_d;
          end
`ifdef SEQ_CHECKER_CONTINUE_EN
          if (val_err) begin
            err_count_q <= sat_inc(err_count_q);
            if (err_code_q == ERR_NONE) begin
              err_code_q  <= ERR_VALUE;
              err_index_q <= count_q;
            end
          end
`endif
          if (term) begin
            state_q <= S_REPORT;
            busy_q  <= 1'b0;
            if (term_code == ERR_NONE) begin
`ifdef SEQ_CHECKER_CONTINUE_EN
              if ((err_count_q != '0) || val_err) fail_q <= 1'b1;
              else                                pass_q <= 1'b1;
`else
              pass_q <= 1'b1;
`endif
            end else begin
              fail_q <= 1'b1;
`ifdef SEQ_CHECKER_CONTINUE_EN
              // Only the first error is kept; a mismatch this cycle already counts as it.
              if ((err_code_q == ERR_NONE) && !val_err) begin
                err_code_q  <= term_code;
                err_index_q <= term_idx;
              end
`else
              err_code_q  <= term_code;
              err_index_q <= term_idx;
`endif
            end
          end else if (acc) begin
            state_q <= S_TRACK;
          end
        end

        S_REPORT: begin
          // The verdict stays held through IDLE until the next arm.
          if (!enable) state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign pass         = pass_q;
  assign fail         = fail_q;
  assign err_code     = err_code_q;
  assign err_index    = err_index_q;
  assign sample_count = count_q;
  assign expected     = expected_q;
`ifdef SEQ_CHECKER_CONTINUE_EN
  assign err_count    = err_count_q;
`endif

endmodule

// File: tb/tb_sequence_checker.sv
// Directed testbench for sequence_checker (default build and SEQ_CHECKER_CONTINUE_EN).
module tb_sequence_checker;

  localparam int DW = 32;
  localparam int CW = 16;

  logic                 clk;
  logic                 rst;
  logic                 enable;
  logic signed [DW-1:0] start_value;
  logic signed [DW-1:0] step;
  logic signed [DW-1:0] range_min;
  logic signed [DW-1:0] range_max;
  logic                 seq_valid;
  logic signed [DW-1:0] seq_value;
  logic                 seq_done;
  logic                 busy;
  logic                 pass;
  logic                 fail;
  logic [2:0]           err_code;
  logic [CW-1:0]        err_index;
  logic [CW-1:0]        sample_count;
  logic signed [DW-1:0] expected;
`ifdef SEQ_CHECKER_CONTINUE_EN
  logic [CW-1:0]        err_count;
`endif

  int tests;
  int fails;

  sequence_checker #(.DATA_W(DW), .CNT_W(CW), .TIMEOUT_CYC(1024)) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .start_value(start_value),
    .step(step),
    .range_min(range_min),
    .range_max(range_max),
    .seq_valid(seq_valid),
    .seq_value(seq_value),
    .seq_done(seq_done),
    .busy(busy),
    .pass(pass),
    .fail(fail),
    .err_code(err_code),
    .err_index(err_index),
    .sample_count(sample_count),
    .expected(expected)
`ifdef SEQ_CHECKER_CONTINUE_EN
    ,
    .err_count(err_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic signed [DW-1:0] s, input logic signed [DW-1:0] st,
                     input logic signed [DW-1:0] mn, input logic signed [DW-1:0] mx);
    start_value = s;
    step        = st;
    range_min   = mn;
    range_max   = mx;
    enable      = 1'b1;
    tick();
  endtask

  task automatic send(input logic signed [DW-1:0] v, input logic d);
    seq_valid = 1'b1;
    seq_value = v;
    seq_done  = d;
    tick();
    seq_valid = 1'b0;
    seq_done  = 1'b0;
  endtask

  task automatic done_pulse;
    seq_done = 1'b1;
    tick();
    seq_done = 1'b0;
  endtask

  task automatic disarm;
    enable = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b0; seq_valid = 1'b0; seq_done = 1'b0; seq_value = '0;
    start_value = '0; step = '0; range_min = '0; range_max = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b want 0", busy); end
    tests++; if (pass !== 1'b0 || fail !== 1'b0) begin fails++; $display("FAIL reset_verdict: got pass=%0b fail=%0b want 0/0", pass, fail); end
    tests++; if (err_code !== 3'd0 || err_index !== '0) begin fails++; $display("FAIL reset_err: got code=%0d idx=%0d want 0/0", err_code, err_index); end
    tests++; if (sample_count !== '0 || expected !== '0) begin fails++; $display("FAIL reset_count: got cnt=%0d exp=%0d want 0/0", sample_count, expected); end
  endtask

  task automatic test_basic_pass;
    arm(0, 3, 0, 10);
    tests++; if (busy !== 1'b1 || expected !== 32'sd0) begin fails++; $display("FAIL basic_arm: got busy=%0b exp=%0d want 1/0", busy, expected); end
    send(0, 1'b0);
    tests++; if (sample_count !== 16'd1 || expected !== 32'sd3) begin fails++; $display("FAIL basic_first: got cnt=%0d exp=%0d want 1/3", sample_count, expected); end
    send(3, 1'b0); send(6, 1'b0); send(9, 1'b0);
    tests++; if (expected !== 32'sd12 || busy !== 1'b1 || pass !== 1'b0) begin fails++; $display("FAIL basic_track: got exp=%0d busy=%0b pass=%0b want 12/1/0", expected, busy, pass); end
    done_pulse();
    tests++; if (pass !== 1'b1 || fail !== 1'b0) begin fails++; $display("FAIL basic_verdict: got pass=%0b fail=%0b want 1/0", pass, fail); end
    tests++; if (sample_count !== 16'd4 || err_code !== 3'd0 || busy !== 1'b0) begin fails++; $display("FAIL basic_count: got cnt=%0d code=%0d busy=%0b want 4/0/0", sample_count, err_code, busy); end
    disarm();
    tests++; if (pass !== 1'b1) begin fails++; $display("FAIL basic_held: got pass=%0b want 1", pass); end
  endtask

  task automatic test_neg_step;
    arm(10, -4, 0, 10);
    tests++; if (pass !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL neg_rearm: got pass=%0b busy=%0b want 0/1", pass, busy); end
    send(10, 1'b0); send(6, 1'b0);
    tests++; if (expected !== 32'sd2) begin fails++; $display("FAIL neg_expected: got %0d want 2", expected); end
    send(2, 1'b1);
    tests++; if (pass !== 1'b1 || fail !== 1'b0 || sample_count !== 16'd3) begin fails++; $display("FAIL neg_verdict: got pass=%0b fail=%0b cnt=%0d want 1/0/3", pass, fail, sample_count); end
    disarm();
  endtask

  task automatic test_value_err;
    arm(0, 3, 0, 10);
    send(0, 1'b0); send(3, 1'b0); send(7, 1'b0);
`ifdef SEQ_CHECKER_CONTINUE_EN
    tests++; if (fail !== 1'b0 || busy !== 1'b1 || err_count !== 16'd1 || err_code !== 3'd2) begin fails++; $display("FAIL value_cont: got fail=%0b busy=%0b ecnt=%0d code=%0d want 0/1/1/2", fail, busy, err_count, err_code); end
    tests++; if (expected !== 32'sd9) begin fails++; $display("FAIL value_cont_exp: got %0d want 9", expected); end
    send(9, 1'b1);
    tests++; if (fail !== 1'b1 || pass !== 1'b0 || err_code !== 3'd2 || err_index !== 16'd2) begin fails++; $display("FAIL value_cont_end: got fail=%0b pass=%0b code=%0d idx=%0d want 1/0/2/2", fail, pass, err_code, err_index); end
`else
    tests++; if (fail !== 1'b1 || pass !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL value_verdict: got fail=%0b pass=%0b busy=%0b want 1/0/0", fail, pass, busy); end
    tests++; if (err_code !== 3'd2 || err_index !== 16'd2 || sample_count !== 16'd2) begin fails++; $display("FAIL value_code: got code=%0d idx=%0d cnt=%0d want 2/2/2", err_code, err_index, sample_count); end
    send(9, 1'b0);
    tests++; if (sample_count !== 16'd2 || err_code !== 3'd2) begin fails++; $display("FAIL value_report_ignore: got cnt=%0d code=%0d want 2/2", sample_count, err_code); end
`endif
    disarm();
  endtask

  task automatic test_early_done;
    arm(0, 3, 0, 10);
    send(0, 1'b0); send(3, 1'b0);
    done_pulse();
    tests++; if (fail !== 1'b1 || pass !== 1'b0 || err_code !== 3'd3) begin fails++; $display("FAIL early_done: got fail=%0b pass=%0b code=%0d want 1/0/3", fail, pass, err_code); end
    disarm();
  endtask

  task automatic test_overrun;
    arm(0, 3, 0, 10);
    send(0, 1'b0); send(3, 1'b0); send(6, 1'b0); send(9, 1'b0); send(12, 1'b0);
    tests++; if (fail !== 1'b1 || pass !== 1'b0 || err_code !== 3'd4 || err_index !== 16'd4) begin fails++; $display("FAIL overrun: got fail=%0b pass=%0b code=%0d idx=%0d want 1/0/4/4", fail, pass, err_code, err_index); end
    tests++; if (sample_count !== 16'd4) begin fails++; $display("FAIL overrun_count: got %0d want 4", sample_count); end
    disarm();
  endtask

  task automatic test_cfg;
    arm(0, 0, 0, 10);
    tests++; if (fail !== 1'b1 || err_code !== 3'd1 || busy !== 1'b0) begin fails++; $display("FAIL cfg_step0: got fail=%0b code=%0d busy=%0b want 1/1/0", fail, err_code, busy); end
    disarm();
    arm(20, 1, 0, 10);
    tests++; if (fail !== 1'b1 || err_code !== 3'd1) begin fails++; $display("FAIL cfg_range: got fail=%0b code=%0d want 1/1", fail, err_code); end
    disarm();
  endtask

  task automatic test_no_wrap;
    arm(32'sh7FFF_FFFE, 1, 0, 32'sh7FFF_FFFF);
    send(32'sh7FFF_FFFE, 1'b0);
    send(32'sh7FFF_FFFF, 1'b0);
    tests++; if (busy !== 1'b1 || fail !== 1'b0) begin fails++; $display("FAIL nowrap_track: got busy=%0b fail=%0b want 1/0", busy, fail); end
    done_pulse();
    tests++; if (pass !== 1'b1 || fail !== 1'b0 || sample_count !== 16'd2) begin fails++; $display("FAIL nowrap_verdict: got pass=%0b fail=%0b cnt=%0d want 1/0/2", pass, fail, sample_count); end
    disarm();
  endtask

  task automatic test_timeout;
    arm(0, 3, 0, 10);
    send(0, 1'b0);
    repeat (1023) tick();
    tests++; if (busy !== 1'b1 || fail !== 1'b0) begin fails++; $display("FAIL timeout_early: got busy=%0b fail=%0b want 1/0", busy, fail); end
    tick();
    tests++; if (fail !== 1'b1 || err_code !== 3'd5 || err_index !== 16'd1) begin fails++; $display("FAIL timeout: got fail=%0b code=%0d idx=%0d want 1/5/1", fail, err_code, err_index); end
    disarm();
  endtask

  task automatic test_abort;
    arm(0, 3, 0, 10);
    send(0, 1'b0); send(3, 1'b0);
    enable = 1'b0;
    tick();
    tests++; if (fail !== 1'b1 || err_code !== 3'd6 || err_index !== 16'd2 || busy !== 1'b0) begin fails++; $display("FAIL abort: got fail=%0b code=%0d idx=%0d busy=%0b want 1/6/2/0", fail, err_code, err_index, busy); end
    tick();
    tests++; if (fail !== 1'b1 || err_code !== 3'd6) begin fails++; $display("FAIL abort_held: got fail=%0b code=%0d want 1/6", fail, err_code); end
    disarm();
  endtask

  task automatic test_rst_mid;
    arm(0, 3, 0, 10);
    send(0, 1'b0); send(3, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    tests++; if (busy !== 1'b0 || sample_count !== '0 || expected !== '0) begin fails++; $display("FAIL rst_mid: got busy=%0b cnt=%0d exp=%0d want 0/0/0", busy, sample_count, expected); end
    tests++; if (pass !== 1'b0 || fail !== 1'b0 || err_code !== 3'd0) begin fails++; $display("FAIL rst_mid_verdict: got pass=%0b fail=%0b code=%0d want 0/0/0", pass, fail, err_code); end
    enable = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_release: got busy=%0b want 0", busy); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic_pass();
    test_neg_step();
    test_value_err();
    test_early_done();
    test_overrun();
    test_cfg();
    test_no_wrap();
    test_timeout();
    test_abort();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
